// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 4-bit ALU and its downstream result buffer:
//   - ALU op-select encodings
//   - result data width
//   - buffered entry layout {perr, sel[2:0], data[DW-1:0]}
//   - parity re-check helper
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int DW    = 8;
    localparam int SEL_W = 3;

    // Entry layout inside the result FIFO, LSB first: data, sel, perr.
    localparam int ENTRY_W  = DW + SEL_W + 1;
    localparam int SEL_LSB  = DW;
    localparam int PERR_BIT = DW + SEL_W;

    typedef enum logic [2:0] {
        OP_NAND   = 3'b000,
        OP_NOR    = 3'b001,
        OP_XOR    = 3'b010,
        OP_ADD    = 3'b011,
        OP_SUB    = 3'b100,
        OP_SHL    = 3'b101,
        OP_SHR    = 3'b110,
        OP_ROTMUL = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic             perr;
        logic [SEL_W-1:0] sel;
        logic [DW-1:0]    data;
    } entry_t;

    // High when the reported parity bit disagrees with the XOR of the data.
    function automatic logic parity_err(input logic [DW-1:0] data, input logic parity);
        return (^data) ^ parity;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Generic single-clock FIFO with show-ahead read. Occupancy is tracked with an
// explicit counter so full/empty never depend on pointer comparison.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (storage not reset)
//   push_i, wdata_i write request and data (ignored when full)
//   pop_i           read request (ignored when empty)
//   rdata_o         head entry, forced to zero while empty
//   count_o         occupancy 0..DEPTH
//   full_o, empty_o occupancy flags
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int W     = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push_s;
    logic          do_pop_s;

    assign full_o    = (cnt_q == CNT_FULL);
    assign empty_o   = (cnt_q == {(AW+1){1'b0}});
    assign count_o   = cnt_q;
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;

    // Show-ahead head: never expose unwritten storage while empty.
    always_comb begin
        rdata_o = {W{1'b0}};
        if (empty_o) begin
            rdata_o = {W{1'b0}};
        end else begin
            rdata_o = mem_q[rd_q];
        end
    end

    // Next-state for pointers and occupancy; pointers wrap naturally.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push_s) begin
            wr_d = wr_q + PTR_ONE;
        end else begin
            wr_d = wr_q;
        end
        if (do_pop_s) begin
            rd_d = rd_q + PTR_ONE;
        end else begin
            rd_d = rd_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= {AW{1'b0}};
            rd_q  <= {AW{1'b0}};
            cnt_q <= {(AW+1){1'b0}};
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage write; a push in the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && do_push_s) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/alu_result_buffer.sv
// -----------------------------------------------------------------------------
// alu_result_buffer
// Captures ALU results with their op select, re-checks the reported parity,
// queues {perr, sel, data} in a FIFO and drains it over valid/ready. Keeps a
// saturating count of accepted entries that failed the parity check.
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   in_valid/in_ready                 producer handshake (in_ready = !full)
//   alu_in, sel_in, parity_in         result, op select, reported parity
//   out_valid/out_ready               consumer handshake (out_valid = !empty)
//   out_data, out_sel, out_perr       head entry fields (zero while empty)
//   count, full, empty                occupancy status
//   clr_err, err_cnt                  error counter clear / value
// -----------------------------------------------------------------------------
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = alu_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] alu_in,
    input  logic [2:0]    sel_in,
    input  logic          parity_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [2:0]    out_sel,
    output logic          out_perr,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    input  logic          clr_err,
    output logic [7:0]    err_cnt
);

    localparam int EW = DW + 4;

    logic          push_s;
    logic          pop_s;
    logic          perr_s;
    logic [EW-1:0] wentry_s;
    logic [EW-1:0] head_s;
    logic [7:0]    err_q, err_d;

    assign perr_s   = parity_err(alu_in, parity_in);
    assign wentry_s = {perr_s, sel_in, alu_in};
    assign in_ready = ~full;
    assign push_s   = in_valid & in_ready;
    assign out_valid = ~empty;
    assign pop_s    = out_valid & out_ready;

    sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .wdata_i (wentry_s),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign out_data = head_s[DW-1:0];
    assign out_sel  = head_s[DW+2:DW];
    assign out_perr = head_s[DW+3];

    // Error counter next-state: clear wins over a same-cycle increment.
    always_comb begin
        err_d = err_q;
        if (clr_err) begin
            err_d = 8'h00;
        end else if (push_s && perr_s && (err_q != 8'hFF)) begin
            err_d = err_q + 8'h01;
        end else begin
            err_d = err_q;
        end
    end

    // Error counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 8'h00;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_cnt = err_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
module tb_alu_result_buffer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] alu_in;
    logic [2:0] sel_in;
    logic       parity_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_sel;
    logic       out_perr;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       clr_err;
    logic [7:0] err_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    alu_result_buffer #(.DEPTH(8), .AW(3), .DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_in    (alu_in),
        .sel_in    (sel_in),
        .parity_in (parity_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_perr  (out_perr),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .clr_err   (clr_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic [2:0] s;
        logic       p;
        logic       ordy;
        logic       clr;
        logic [3:0] e_count;
        logic       e_ov;
        logic [7:0] e_data;
        logic [2:0] e_sel;
        logic       e_perr;
        logic [7:0] e_err;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [7:0] d, input logic [2:0] s,
                         input logic p, input logic ordy, input logic clr);
        in_valid  = iv;
        alu_in    = d;
        sel_in    = s;
        parity_in = p;
        out_ready = ordy;
        clr_err   = clr;
    endtask

    initial begin
        // Directed table: inputs for one edge, expected state after it.
        //        iv    data   sel   par   ordy  clr   cnt   ov    data   sel   perr  err
        vt[0]  = '{1'b1, 8'h5A, 3'd5, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 8'h5A, 3'd5, 1'b0, 8'd0};
        vt[1]  = '{1'b1, 8'h07, 3'd0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 8'h5A, 3'd5, 1'b0, 8'd0};
        vt[2]  = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 8'h07, 3'd0, 1'b0, 8'd0};
        vt[3]  = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 3'd0, 1'b0, 8'd0};
        vt[4]  = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 3'd0, 1'b0, 8'd0};
        vt[5]  = '{1'b1, 8'h03, 3'd3, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 8'h03, 3'd3, 1'b1, 8'd1};
        vt[6]  = '{1'b1, 8'h03, 3'd3, 1'b1, 1'b0, 1'b1, 4'd2, 1'b1, 8'h03, 3'd3, 1'b1, 8'd0};
        vt[7]  = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 8'h03, 3'd3, 1'b1, 8'd0};
        vt[8]  = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 3'd0, 1'b0, 8'd0};
        vt[9]  = '{1'b1, 8'h81, 3'd7, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 8'h81, 3'd7, 1'b0, 8'd0};
        vt[10] = '{1'b1, 8'h42, 3'd2, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 8'h42, 3'd2, 1'b1, 8'd1};
        vt[11] = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 3'd0, 1'b0, 8'd1};
        vt[12] = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 8'h00, 3'd0, 1'b0, 8'd0};

        // ---------------- reset, then reset mid-stream -----------------
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);

        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h01, 3'(i), 1'b0, 1'b0, 1'b0);  // bad parity
            tick();
        end
        chk("pre_rst_count", 32'(count), 32'd3);
        chk("pre_rst_err", 32'(err_cnt), 32'd3);
        rst_n = 1'b0;
        drive(1'b1, 8'h55, 3'd1, 1'b1, 1'b1, 1'b0);
        tick();
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        chk("midrst_err", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("post_rst_count", 32'(count), 32'd0);

        // ---------------- table-driven vectors -------------------------
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].iv, vt[i].d, vt[i].s, vt[i].p, vt[i].ordy, vt[i].clr);
            tick();
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].e_count));
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
            chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vt[i].e_data));
            chk($sformatf("vec%0d_out_sel", i), 32'(out_sel), 32'(vt[i].e_sel));
            chk($sformatf("vec%0d_out_perr", i), 32'(out_perr), 32'(vt[i].e_perr));
            chk($sformatf("vec%0d_err", i), 32'(err_cnt), 32'(vt[i].e_err));
        end

        // ---------------- fill, full-with-pop, wrap-around -------------
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 8'(i), 3'(i), ^(8'(i)), 1'b0, 1'b0);
            tick();
        end
        chk("fill_count", 32'(count), 32'd8);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_head", 32'(out_data), 32'd1);
        drive(1'b1, 8'd9, 3'd1, ^(8'd9), 1'b1, 1'b0);
        tick();
        chk("full_pop_count", 32'(count), 32'd7);
        chk("full_pop_head", 32'(out_data), 32'd2);
        chk("full_pop_full", 32'(full), 32'd0);
        out_ready = 1'b0;  // 9th entry still held on the inputs
        tick();
        chk("held_push_count", 32'(count), 32'd8);
        chk("held_push_full", 32'(full), 32'd1);
        drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 2; i <= 9; i++) begin
            chk($sformatf("drain_data_%0d", i), 32'(out_data), 32'(i));
            chk($sformatf("drain_sel_%0d", i), 32'(out_sel), 32'(i % 8));
            chk($sformatf("drain_perr_%0d", i), 32'(out_perr), 32'd0);
            tick();
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_out_data", 32'(out_data), 32'd0);

        // ---------------- continuous streaming -------------------------
        drive(1'b1, 8'h10, 3'd0, ^(8'h10), 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("stream_head_%0d", i), 32'(out_data), 32'(8'h10 + 8'(i)));
            drive(1'b1, 8'h11 + 8'(i), 3'(i), ^(8'h11 + 8'(i)), 1'b1, 1'b0);
            tick();
            chk($sformatf("stream_count_%0d", i), 32'(count), 32'd1);
        end
        chk("stream_last", 32'(out_data), 32'h24);
        drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("stream_empty", 32'(empty), 32'd1);
        chk("stream_err", 32'(err_cnt), 32'd0);

        // ---------------- error counter saturation ---------------------
        for (int i = 1; i <= 300; i++) begin
            drive(1'b1, 8'h01, 3'd7, 1'b0, 1'b1, 1'b0);
            tick();
            if (i == 254) chk("sat_err_254", 32'(err_cnt), 32'd254);
            if (i == 255) chk("sat_err_255", 32'(err_cnt), 32'd255);
        end
        chk("sat_err_300", 32'(err_cnt), 32'd255);
        chk("sat_count", 32'(count), 32'd1);
        drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1);
        tick();
        chk("sat_clear", 32'(err_cnt), 32'd0);
        chk("sat_final_empty", 32'(empty), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Downstream stage of the 4-bit ALU. It captures each 8-bit ALU result together with its op select and parity bit.
- It re-checks parity on every accepted result and flags mismatches.
- Results are queued in a small FIFO and drained to the consumer (display/checker) over a valid/ready handshake.
- A saturating parity-error counter is kept for debug.

Parameters:
- DEPTH, 8, number of FIFO entries (power of two, ≥2)
- AW, 3, pointer width = log2(DEPTH)
- DW, 8, result data width (matches ALU output)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  producer has a result this cycle
- in_ready  output  1  buffer can accept (= !full)
- alu_in  input  DW  ALU result
- sel_in  input  3  op select that produced alu_in
- parity_in  input  1  parity bit reported by ALU (XOR of alu)
- out_valid  output  1  head entry available
- out_ready  input  1  consumer takes head this cycle
- out_data  output  DW  head result
- out_sel  output  3  head op select
- out_perr  output  1  head entry failed parity check
- count  output  AW+1  current occupancy 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- clr_err  input  1  clear error counter
- err_cnt  output  8  saturating count of accepted entries with parity error

Behaviour:
- One clock domain; all state updates on rising clk.
- Reset is synchronous and active-low: when rst_n=0 at a clk edge:
  - write pointer, read pointer, count and err_cnt are set to 0
  - full=0, empty=1, in_ready=1, out_valid=0
  - out_data, out_sel and out_perr all read 0 while empty
  - storage array is not reset
- Reset mid-operation discards all queued entries. A push or pop in the reset cycle is ignored.
- Push: occurs when in_valid && in_ready at an edge.
  - The entry {alu_in, sel_in, perr} is written at wr_ptr, and wr_ptr increments modulo DEPTH.
  - perr = (^alu_in) XOR parity_in, computed combinationally at write time.
- Pop: occurs when out_valid && out_ready at an edge; rd_ptr increments modulo DEPTH.
- Show-ahead read: out_data, out_sel and out_perr are combinational from the array at rd_ptr, gated to 0 when empty.
- out_valid = !empty.
- Latency: an entry pushed at edge N is visible (out_valid=1) after edge N, i.e. in cycle N+1. No same-cycle bypass.
- Count update per edge:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
- in_ready = !full, so when full no push is accepted even if a pop happens in the same cycle. The slot frees for the next cycle.
- When empty a pop cannot occur (out_valid=0), so only a push is possible.
- Pointer wrap: AW-bit pointers wrap naturally. full/empty are derived from count, not from pointer compare.
- in_valid while full: the producer must hold alu_in/sel_in/parity_in stable until in_ready=1. The buffer does not drop or overwrite.
- err_cnt:
  - increments by 1 on each accepted push with perr=1
  - saturates at 255
  - clr_err=1 sets it to 0, and clr_err has priority over a same-cycle increment (that increment is lost)
- No X propagation: outputs are never driven from unwritten storage, because out_* is gated by empty.

Decomposition:
- Shared package alu_pkg holds:
  - the ALU op-select encodings OP_NAND=3'b000 … OP_ROTMUL=3'b111
  - DW=8
  - an entry struct/concat layout {perr, sel[2:0], data[7:0]} (12 bits)
- One natural sub-module: sync_fifo (generic DEPTH/width storage + pointers + count).
- alu_result_buffer wraps sync_fifo and adds the parity check, field packing and err_cnt.

Test Plan:
- Reset then idle, asserting rst_n=0 mid-stream with 3 entries queued → after the edge, count=0, empty=1, out_valid=0, out_data=0, err_cnt=0.
- Push alu_in=8'h5A (sel=3'b101) with parity_in=0, then 8'h07 (sel=3'b000) with parity_in=1, out_ready=0 → count=2. Then out_ready=1 → pops 5A/sel 101/perr 0, then 07/sel 000/perr 0 (^07=1), then empty.
- Push 8'h03 with parity_in=1 (wrong; ^03=0) → out_perr=1 at head, err_cnt=1. Pulse clr_err on a cycle that also pushes a bad entry → err_cnt=0.
- Fill 8 entries (values 1..8) with out_ready=0 → full=1, in_ready=0. A 9th in_valid with out_ready=1 in the same cycle → only the pop happens, count=7. The held 9th is accepted next cycle, count=8. Drain order is 2..9, confirming wrap-around.
- Continuous streaming with in_valid=1 and out_ready=1 for 20 cycles from 1 entry → count stays 1, outputs appear in push order with one-cycle latency.
- 300 bad-parity pushes interleaved with pops → err_cnt saturates at 255 and holds.
